rho_pi_permuter: RTL and testbench

RHO_PI_PERMUTER -- requirements
Module: rho_pi_permuter

---
 rtl/rho_pi_permuter.sv | 102 ++++++++++
 tb/tb_rho_pi_permuter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rho_pi_permuter.sv
// Slice-serial Keccak rho/pi permuter: buffers SLICES 25-bit slices, then streams
// the permuted state back out one slice per cycle.
module rho_pi_permuter #(
    parameter int SLICES = 64,
    parameter int CW     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [24:0] in,
    output logic        read,
    output logic        ready,
    output logic [24:0] out,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_e;

    // Keccak rotation offsets, indexed by lane number x+5y.
    localparam int RHO_OFF [25] = '{ 0,  1, 62, 28, 27,
                                    36, 44,  6, 55, 20,
                                     3, 10, 43, 25, 39,
                                    41, 45, 15, 21,  8,
                                    18,  2, 61, 56, 14};
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [24:0]     buf_q [SLICES];
    logic [24:0]     result;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    mode_d  = mode;
                end
            end
            LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = OUT;
            end
            OUT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // NOTE: the slice buffer is deliberately not reset; it is always fully
    // rewritten in LOAD before OUT can expose any entry.
    always_ff @(posedge clk) begin
        if (state_q == LOAD) buf_q[cnt_q] <= in;
    end

    // Each result lane reads its pi source lane from the slice rotated back by
    // that source lane's rho offset; CW-bit subtraction gives the mod-SLICES wrap.
    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar x = 0; x < 5; x++) begin : g_x
            localparam int            ID_SRC = x + 5 * y;
            localparam int            PI_SRC = ((x + 3 * y) % 5) + 5 * x;
            localparam logic [CW-1:0] ROT_ID = CW'(RHO_OFF[ID_SRC]);
            localparam logic [CW-1:0] ROT_PI = CW'(RHO_OFF[PI_SRC]);

            logic [CW-1:0] rot;
            logic [CW-1:0] addr;

            assign rot  = mode_q[1] ? (mode_q[0] ? ROT_PI : ROT_ID) : '0;
            assign addr = cnt_q - rot;
            assign result[ID_SRC] = mode_q[0] ? buf_q[addr][PI_SRC] : buf_q[addr][ID_SRC];
        end
    end

    assign read  = (state_q == LOAD);
    assign ready = (state_q == OUT);
    assign busy  = (state_q != IDLE);
    assign out   = ready ? result : '0;

endmodule

// File: tb/tb_rho_pi_permuter.sv
// Bench for rho_pi_permuter: directed vector table, lane-level reference model on
// random states, and hand sequences for timing, start filtering and reset.
module tb_rho_pi_permuter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [1:0]  mode_i;
    logic [24:0] in_i;
    logic        read_a, ready_a, busy_a;
    logic        read_b, ready_b, busy_b;
    logic [24:0] out_a, out_b;

    logic        cur_b;
    logic [2:0]  flags;
    logic [24:0] out_c;

    int checks = 0;
    int errors = 0;

    logic [24:0] src  [64];
    logic [24:0] expv [64];

    // Rotation offsets in the customary r[x][y] layout.
    int r_tab [5][5] = '{'{ 0, 36,  3, 41, 18},
                         '{ 1, 44, 10, 45,  2},
                         '{62,  6, 43, 15, 61},
                         '{28, 55, 25, 21, 56},
                         '{27, 20, 39,  8, 14}};

    typedef struct {
        logic [1:0] mode;
        int         n;
        int         src_lane;
        int         src_slice;
        int         exp_lane;
        int         exp_slice;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    rho_pi_permuter #(.SLICES(64), .CW(6)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_i), .in(in_i),
        .read(read_a), .ready(ready_a), .out(out_a), .busy(busy_a)
    );

    rho_pi_permuter #(.SLICES(8), .CW(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_i), .in(in_i),
        .read(read_b), .ready(ready_b), .out(out_b), .busy(busy_b)
    );

    assign flags = cur_b ? {read_b, ready_b, busy_b} : {read_a, ready_a, busy_a};
    assign out_c = cur_b ? out_b : out_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur_b) start_b = v;
        else       start_a = v;
    endtask

    // Reference: unpack slices into lanes, rotate each lane, then move lanes.
    task automatic model(input int n, input logic [1:0] m);
        logic [63:0] lane [5][5];
        logic [63:0] rot  [5][5];
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                int r;
                lane[x][y] = '0;
                rot[x][y]  = '0;
                for (int z = 0; z < n; z++) lane[x][y][z] = src[z][x + 5 * y];
                r = m[1] ? (r_tab[x][y] % n) : 0;
                for (int z = 0; z < n; z++) rot[x][y][(z + r) % n] = lane[x][y][z];
            end
        end
        for (int z = 0; z < n; z++) begin
            expv[z] = '0;
            for (int x = 0; x < 5; x++) begin
                for (int y = 0; y < 5; y++) begin
                    expv[z][x + 5 * y] = m[0] ? rot[(x + 3 * y) % 5][x][z] : rot[x][y][z];
                end
            end
        end
    endtask

    // One full operation; noisy toggles start and mode while busy.
    task automatic run_op(input logic sel, input int n, input logic [1:0] m, input logic noisy);
        cur_b = sel;
        @(negedge clk);
        set_start(1'b1);
        mode_i = m;
        @(negedge clk);
        for (int z = 0; z < n; z++) begin
            check($sformatf("n%0d m%0d load z%0d", n, m, z), {4'b0, flags, out_c}, {4'b0, 3'b101, 25'b0});
            in_i = src[z];
            if (noisy) begin
                set_start(1'($urandom_range(1)));
                mode_i = 2'($urandom);
            end else begin
                set_start(1'b0);
            end
            @(negedge clk);
        end
        for (int z = 0; z < n; z++) begin
            check($sformatf("n%0d m%0d out z%0d", n, m, z), {4'b0, flags, out_c}, {4'b0, 3'b011, expv[z]});
            in_i = 25'($urandom);
            if (noisy) begin
                set_start(1'($urandom_range(1)));
                mode_i = 2'($urandom);
            end
            @(negedge clk);
        end
        set_start(1'b0);
        check($sformatf("n%0d m%0d idle after", n, m), {4'b0, flags, out_c}, 32'b0);
    endtask

    initial begin
        start_a = 1'b0;
        start_b = 1'b0;
        mode_i  = 2'b00;
        in_i    = '0;
        cur_b   = 1'b0;
        rst     = 1'b0;

        #1;
        check("reset a", {4'b0, flags, out_c}, 32'b0);
        cur_b = 1'b1;
        #1;
        check("reset b", {4'b0, flags, out_c}, 32'b0);
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (2) @(negedge clk);
        check("reset held b", {4'b0, flags, out_c}, 32'b0);
        cur_b = 1'b0;
        #1;
        check("reset held a", {4'b0, flags, out_c}, 32'b0);
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single set bit in, single set bit out: hand-derived placements.
        vecs[0]  = '{2'b00, 64,  7, 0,  7,  0};
        vecs[1]  = '{2'b01, 64,  1, 0, 10,  0};
        vecs[2]  = '{2'b10, 64,  1, 0,  1,  1};
        vecs[3]  = '{2'b10, 64,  2, 0,  2, 62};
        vecs[4]  = '{2'b10, 64,  5, 0,  5, 36};
        vecs[5]  = '{2'b01, 64,  5, 0, 16,  0};
        vecs[6]  = '{2'b11, 64,  1, 0, 10,  1};
        vecs[7]  = '{2'b11, 64, 24, 0,  4, 14};
        vecs[8]  = '{2'b10, 64,  2, 5,  2,  3};
        vecs[9]  = '{2'b10,  8,  2, 0,  2,  6};
        vecs[10] = '{2'b11,  8, 24, 0,  4,  6};
        vecs[11] = '{2'b10,  8,  3, 7,  3,  3};
        for (int v = 0; v < 12; v++) begin
            for (int z = 0; z < 64; z++) begin
                src[z]  = '0;
                expv[z] = '0;
            end
            src[vecs[v].src_slice][vecs[v].src_lane]  = 1'b1;
            expv[vecs[v].exp_slice][vecs[v].exp_lane] = 1'b1;
            run_op(vecs[v].n == 8, vecs[v].n, vecs[v].mode, 1'b0);
        end

        // Pass-through with slice z carrying value z.
        for (int z = 0; z < 64; z++) begin
            src[z]  = 25'(z);
            expv[z] = 25'(z);
        end
        run_op(1'b0, 64, 2'b00, 1'b0);

        // Random states against the lane-level model, with start/mode noise.
        for (int t = 0; t < 10; t++) begin
            logic [1:0] m;
            int         n;
            n = (t % 2 == 1) ? 8 : 64;
            m = 2'(t % 4);
            for (int z = 0; z < 64; z++) src[z] = 25'($urandom);
            model(n, m);
            run_op(t % 2 == 1, n, m, 1'b1);
        end

        // Start held high throughout: fixed timing, one IDLE cycle, then relaunch.
        cur_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        mode_i  = 2'b11;
        for (int c = 1; c <= 130; c++) begin
            logic [2:0] e;
            @(negedge clk);
            in_i = 25'($urandom);
            e = (c <= 64) ? 3'b101 : (c <= 128) ? 3'b011 : (c == 129) ? 3'b000 : 3'b101;
            if (c <= 64 || c > 128)
                check($sformatf("held start c%0d", c), {4'b0, flags, out_c}, {4'b0, e, 25'b0});
            else
                check($sformatf("held start c%0d", c), {29'b0, flags}, {29'b0, e});
        end
        rst = 1'b0;
        #1;
        check("abort relaunch", {4'b0, flags, out_c}, 32'b0);
        start_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset in LOAD cycle 10, then idle until a fresh start.
        @(negedge clk);
        start_a = 1'b1;
        mode_i  = 2'b10;
        @(negedge clk);
        start_a = 1'b0;
        for (int z = 0; z < 9; z++) begin
            in_i = 25'($urandom);
            @(negedge clk);
        end
        check("load cycle 10 reading", {29'b0, flags}, {29'b0, 3'b101});
        rst = 1'b0;
        #1;
        check("reset mid load", {4'b0, flags, out_c}, 32'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("idle after reset c%0d", c), {4'b0, flags, out_c}, 32'b0);
        end
        for (int z = 0; z < 64; z++) src[z] = 25'($urandom);
        model(64, 2'b10);
        run_op(1'b0, 64, 2'b10, 1'b0);

        // Reset in the middle of OUT must blank out immediately.
        @(negedge clk);
        start_a = 1'b1;
        mode_i  = 2'b01;
        @(negedge clk);
        start_a = 1'b0;
        for (int z = 0; z < 64 + 5; z++) begin
            in_i = 25'h1FFFFFF;
            @(negedge clk);
        end
        check("out cycle 6 ready", {29'b0, flags}, {29'b0, 3'b011});
        rst = 1'b0;
        #1;
        check("reset mid out", {4'b0, flags, out_c}, 32'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
